// File: rtl/sap1_controller_sequencer_if.sv
// Control bundle between the SAP-1 sequencer and its datapath.
// The datapath supplies the IR opcode and receives the strobes and state.
interface sap1_controller_sequencer_if;
  logic [3:0] opcode;
  logic       pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en;
  logic       loada, enable, loadb, sub, alu_en, out_load;
  logic [5:0] t_state;
  logic       halted;

  modport master (
    input  opcode,
    output pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
           loada, enable, loadb, sub, alu_en, out_load, t_state, halted
  );
  modport slave (
    output opcode,
    input  pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
           loada, enable, loadb, sub, alu_en, out_load, t_state, halted
  );
endinterface

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control unit: 6-state one-hot ring (T1..T6) with combinational
// strobe decode from ring state and live opcode; HLT freezes the ring at T4.
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic                           clk,
  input  logic                           rst,
  sap1_controller_sequencer_if.master    bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100,
    T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000
  } tstate_e;

  tstate_e state;
  logic    halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= T1;
      halted <= 1'b0;
    end else if (!halted) begin
      if (state == T4 && bus.opcode == OP_HLT) halted <= 1'b1;
      else begin
        case (state)
          T1:      state <= T2;
          T2:      state <= T3;
          T3:      state <= T4;
          T4:      state <= T5;
          T5:      state <= T6;
          default: state <= T1;
        endcase
      end
    end
  end

  assign bus.t_state = state;
  assign bus.halted  = halted;

  // Strobes are gated by rst so they drop the instant reset asserts.
  always_comb begin
    bus.pc_inc = 1'b0; bus.pc_en  = 1'b0; bus.mar_load = 1'b0;
    bus.ram_en = 1'b0; bus.ir_load = 1'b0; bus.ir_en  = 1'b0;
    bus.loada  = 1'b0; bus.enable = 1'b0; bus.loadb    = 1'b0;
    bus.sub    = 1'b0; bus.alu_en = 1'b0; bus.out_load = 1'b0;
    if (rst && !halted) begin
      case (state)
        T1: begin bus.pc_en = 1'b1; bus.mar_load = 1'b1; end
        T2: bus.pc_inc = 1'b1;
        T3: begin bus.ram_en = 1'b1; bus.ir_load = 1'b1; end
        T4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.ir_en = 1'b1; bus.mar_load = 1'b1;
          end else if (bus.opcode == OP_OUT) begin
            bus.enable = 1'b1; bus.out_load = 1'b1;
          end
        end
        T5: begin
          if (bus.opcode == OP_LDA) begin
            bus.ram_en = 1'b1; bus.loada = 1'b1;
          end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.ram_en = 1'b1; bus.loadb = 1'b1;
            bus.sub    = (bus.opcode == OP_SUB);
          end
        end
        T6: begin
          // sub already held in T5 so the ALU result is settled here.
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.alu_en = 1'b1; bus.loada = 1'b1;
            bus.sub    = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
